i2s_dac_tx: RTL

- Transmit side of the codec audio path: serializes filtered 16-bit mono samples onto the DAC data pin in I2S format.
- Codec is bus master and drives BCLK and LRCLK.
- Block synchronizes both clocks into clk, generates the lrclk edge strobes consumed by the filter chain, and shifts the sample MSB-first, one BCLK after each LRCLK transition.
- The same sample is sent on the left and right channels.

---
 rtl/i2s_dac_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the codec DAC path: mono sample sent on both channels, BCLK/LRCLK driven by the codec.
// Optional build macro I2S_TX_MUTE_ON_UNDERRUN_EN: an underrun frame sends silence instead of repeating the last sample.
module i2s_dac_tx #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              i_rst_n,
   input  logic              i_bclk,
   input  logic              i_lrclk,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_audio,
   output logic              o_dacdat,
   output logic              o_lrclk_posedge,
   output logic              o_lrclk_negedge,
   output logic              o_sample_taken,
   output logic              o_underrun
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_DELAY = 3'd2,
      ST_SHIFT = 3'd3,
      ST_PAD   = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] bclk_sync_q, lrclk_sync_q;
   logic                   bclk_hist_q, lrclk_hist_q;
   logic                   bclk_fall_s, lr_rise_s, lr_fall_s, lr_edge_s;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d, frame_q, frame_d, shift_q, shift_d;
   logic              fresh_q, fresh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              dacdat_q, dacdat_d;
   logic              taken_q, taken_d, underrun_q, underrun_d;
   logic              lr_pos_q, lr_neg_q;

   // Synchronizer chains plus one history flop per pin for edge detection
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bclk_sync_q  <= '0;
         lrclk_sync_q <= '0;
         bclk_hist_q  <= 1'b0;
         lrclk_hist_q <= 1'b0;
      end else begin
         bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], i_bclk};
         lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], i_lrclk};
         bclk_hist_q  <= bclk_sync_q[SYNC_STAGES-1];
         lrclk_hist_q <= lrclk_sync_q[SYNC_STAGES-1];
      end
   end

   assign bclk_fall_s = bclk_hist_q & ~bclk_sync_q[SYNC_STAGES-1];
   assign lr_rise_s   = ~lrclk_hist_q & lrclk_sync_q[SYNC_STAGES-1];
   assign lr_fall_s   = lrclk_hist_q & ~lrclk_sync_q[SYNC_STAGES-1];
   assign lr_edge_s   = lr_rise_s | lr_fall_s;

   // Sample capture, frame load and the serializer state machine
   always_comb begin
      hold_d     = hold_q;
      fresh_d    = fresh_q;
      frame_d    = frame_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      dacdat_d   = dacdat_q;
      state_d    = state_q;
      taken_d    = 1'b0;
      underrun_d = 1'b0;

      if (i_valid) begin
         hold_d  = i_audio;
         fresh_d = 1'b1;
      end else begin
         hold_d = hold_q;
      end

      // A same-cycle sample bypasses the hold register; either way the sample is consumed
      if (lr_fall_s) begin
         taken_d = 1'b1;
         fresh_d = 1'b0;
         if (i_valid) begin
            frame_d = i_audio;
         end else if (fresh_q) begin
            frame_d = hold_q;
         end else begin
            underrun_d = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
            frame_d = {DATA_W{1'b0}};
`else
            frame_d = frame_q;
`endif
         end
      end else begin
         taken_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            dacdat_d = 1'b0;
            if (lr_fall_s) state_d = ST_LOAD;
            else           state_d = ST_IDLE;
         end
         ST_LOAD: begin
            shift_d = frame_q;
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_DELAY;
         end
         ST_DELAY: begin
            if (bclk_fall_s) begin
               dacdat_d = shift_q[DATA_W-1];
               shift_d  = {shift_q[DATA_W-2:0], 1'b0};
               cnt_d    = CNT_W'(1);
               state_d  = ST_SHIFT;
            end else begin
               state_d = ST_DELAY;
            end
         end
         ST_SHIFT: begin
            if (bclk_fall_s && (cnt_q == CNT_W'(DATA_W))) begin
               dacdat_d = 1'b0;
               state_d  = ST_PAD;
            end else if (bclk_fall_s) begin
               dacdat_d = shift_q[DATA_W-1];
               shift_d  = {shift_q[DATA_W-2:0], 1'b0};
               cnt_d    = cnt_q + CNT_W'(1);
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_PAD: begin
            if (bclk_fall_s) dacdat_d = 1'b0;
            else             dacdat_d = dacdat_q;
         end
         default: begin
            dacdat_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase

      // Any LRCLK edge once running restarts the word; a coincident BCLK fall is not counted
      if ((state_q != ST_IDLE) && lr_edge_s) begin
         state_d  = ST_LOAD;
         dacdat_d = dacdat_q;
         shift_d  = shift_q;
         cnt_d    = cnt_q;
      end else begin
         cnt_d = cnt_d;
      end
   end

   // State and datapath registers; all outputs come straight from flops
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         hold_q     <= {DATA_W{1'b0}};
         frame_q    <= {DATA_W{1'b0}};
         shift_q    <= {DATA_W{1'b0}};
         fresh_q    <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
         dacdat_q   <= 1'b0;
         taken_q    <= 1'b0;
         underrun_q <= 1'b0;
         lr_pos_q   <= 1'b0;
         lr_neg_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         frame_q    <= frame_d;
         shift_q    <= shift_d;
         fresh_q    <= fresh_d;
         cnt_q      <= cnt_d;
         dacdat_q   <= dacdat_d;
         taken_q    <= taken_d;
         underrun_q <= underrun_d;
         lr_pos_q   <= lr_rise_s;
         lr_neg_q   <= lr_fall_s;
      end
   end

   assign o_dacdat        = dacdat_q;
   assign o_lrclk_posedge = lr_pos_q;
   assign o_lrclk_negedge = lr_neg_q;
   assign o_sample_taken  = taken_q;
   assign o_underrun      = underrun_q;

endmodule
